// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// funct3 access-size codes and byte-enable base patterns.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    function automatic logic f3_valid(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: picks the addressed byte/half lane from the
// memory word and sign- or zero-extends it to the full data width.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{offset, 3'b000} +: 8];
    assign lane_h = rdata[{offset[1], 4'b0000} +: 16];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_B:    result = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            F3_H:    result = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            F3_BU:   result = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            F3_HU:   result = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> DONE handshake to a word-wide memory.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    output logic                  Misaligned
);

    lsu_state_t            state, state_nxt;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [1:0]            off_eff;
    logic                  access;
    logic                  trap;
    logic [3:0]            be_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic [DATA_WIDTH-1:0] load_val;

`ifdef MISALIGN_TRAP_EN
    logic misalign;

    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = ALUResult[0];
            2'b10:   misalign = |ALUResult[1:0];
            default: misalign = 1'b0;
        endcase
    end

    assign access  = (MemRead | MemWrite) & f3_valid(funct3) & ~misalign;
    assign trap    = (MemRead | MemWrite) & f3_valid(funct3) & misalign;
    assign off_eff = ALUResult[1:0];
`else
    assign access = (MemRead | MemWrite) & f3_valid(funct3);
    assign trap   = 1'b0;

    // Natural alignment: drop the low address bits the access size cannot use.
    always_comb begin
        off_eff = ALUResult[1:0];
        case (funct3[1:0])
            2'b01:   off_eff = {ALUResult[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = ALUResult[1:0];
        endcase
    end
`endif

    always_comb begin
        be_nxt    = BE_WORD;
        wdata_nxt = WriteData;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = BE_BYTE << off_eff;
                    wdata_nxt = {(DATA_WIDTH/8){WriteData[7:0]}};
                end
                2'b01: begin
                    be_nxt    = BE_HALF << off_eff;
                    wdata_nxt = {(DATA_WIDTH/16){WriteData[15:0]}};
                end
                default: begin
                    be_nxt    = BE_WORD;
                    wdata_nxt = WriteData;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        Stall     = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    Stall     = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                Stall = 1'b1;
                if (mem_ack) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_we     <= 1'b0;
            mem_be     <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ReadData   <= '0;
            Misaligned <= 1'b0;
            f3_q       <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            state      <= state_nxt;
            Misaligned <= (state == IDLE) && trap;
            if (state == IDLE && access) begin
                mem_we    <= MemWrite;
                mem_be    <= be_nxt;
                mem_addr  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                mem_wdata <= MemWrite ? wdata_nxt : '0;
                f3_q      <= funct3;
                off_q     <= off_eff;
            end
            // Only a load completing in REQ updates the result register.
            if (state == REQ && mem_ack && !mem_we)
                ReadData <= load_val;
        end
    end

    lsu_load_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_val)
    );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/trap sequences and
// randomized accesses against a byte-array memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALUResult = '0, WriteData = '0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] ReadData;
    logic        Stall, Misaligned;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .ReadData(ReadData), .Stall(Stall),
        .Misaligned(Misaligned)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] dmem [0:255];     // memory the DUT talks to
    logic [7:0]  refm [0:1023];    // reference byte memory
    logic [31:0] model_rd;

    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;
    logic        cap_we;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_access(input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input int waits,
                              output int nstall, output int nreq);
        int w;
        bit done;
        logic prev;
        logic [7:0] idx;
        @(negedge clk);
        MemRead = mr; MemWrite = mw; funct3 = f3; ALUResult = addr; WriteData = wd;
        mem_ack = 1'b0;
        nstall = 0; nreq = 0; w = 0; done = 0; prev = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (mem_req && !prev) nreq++;
            prev = mem_req;
            if (!Stall) done = 1;
            else begin
                nstall++;
                if (mem_req) begin
                    if (w == waits) begin
                        idx = mem_addr[9:2];
                        mem_rdata = dmem[idx];
                        cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wdata; cap_we = mem_we;
                        if (mem_we)
                            for (int k = 0; k < 4; k++)
                                if (mem_be[k]) dmem[idx][8*k +: 8] = mem_wdata[8*k +: 8];
                        mem_ack = 1'b1;
                        w = 0;
                    end else w++;
                end
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
        check("access_done", {31'd0, done}, 32'd1);
    endtask

    task automatic idle_cycles(input int n, output int reqs);
        reqs = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            MemRead = 1'b0; MemWrite = 1'b0;
            #1;
            if (mem_req) reqs++;
        end
    endtask

    // Reference behaviour from the access rules, on a flat byte memory.
    task automatic model_step(input logic mr, input logic mw, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output bit acc, output logic [3:0] ebe,
                              output logic [31:0] ewd, output logic [31:0] eaddr);
        int size, ea;
        longint unsigned v;
        acc = 0; ebe = 4'hF; ewd = 32'h0; eaddr = 32'h0;
        if (!(mr || mw) || f3 == 3'd3 || f3 >= 3'd6) return;
        size = 1 << f3[1:0];
`ifdef MISALIGN_TRAP_EN
        if (int'(addr) % size != 0) return;
`endif
        ea = int'(addr) - int'(addr) % size;
        acc = 1;
        eaddr = 32'(ea - ea % 4);
        if (mw) begin
            for (int i = 0; i < size; i++) refm[ea + i] = wd[8*i +: 8];
            ebe = 4'(((1 << size) - 1) << (ea % 4));
            if (size == 1)      ewd = {24'd0, wd[7:0]} * 32'h01010101;
            else if (size == 2) ewd = {16'd0, wd[15:0]} * 32'h00010001;
            else                ewd = wd;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v | (longint'(refm[ea + i]) << (8*i));
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 1);
            model_rd = v[31:0];
        end
    endtask

    typedef struct {
        logic mr; logic mw; logic [2:0] f3; logic [31:0] addr; logic [31:0] wd;
        bit pre; logic [31:0] pre_val; int waits;
        int e_stall; int e_req; logic e_we; logic [3:0] e_be;
        logic [31:0] e_wd; logic [31:0] e_addr; logic [31:0] e_rd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int ns, nr, nr2, mis_cnt, req_cnt;
        bit acc;
        logic [3:0] ebe;
        logic [31:0] ewd, eaddr;

        tbl[0]  = '{1,0,3'd2,32'h100,32'h0,      1,32'hDEADBEEF,2, 4,1,0,4'hF,32'h0,       32'h100,32'hDEADBEEF};
        tbl[1]  = '{1,0,3'd0,32'h103,32'h0,      1,32'h80FF0000,0, 2,1,0,4'hF,32'h0,       32'h100,32'hFFFFFF80};
        tbl[2]  = '{1,0,3'd4,32'h103,32'h0,      0,32'h0,       0, 2,1,0,4'hF,32'h0,       32'h100,32'h00000080};
        tbl[3]  = '{1,0,3'd1,32'h102,32'h0,      0,32'h0,       1, 3,1,0,4'hF,32'h0,       32'h100,32'hFFFF80FF};
        tbl[4]  = '{1,0,3'd5,32'h100,32'h0,      1,32'h12348001,0, 2,1,0,4'hF,32'h0,       32'h100,32'h00008001};
        tbl[5]  = '{0,1,3'd1,32'h202,32'h1234ABCD,1,32'h0,      0, 2,1,1,4'hC,32'hABCDABCD,32'h200,32'h00008001};
        tbl[6]  = '{0,1,3'd0,32'h201,32'h00000055,0,32'h0,      0, 2,1,1,4'h2,32'h55555555,32'h200,32'h00008001};
        tbl[7]  = '{1,0,3'd3,32'h300,32'h0,      0,32'h0,       0, 0,0,0,4'h0,32'h0,       32'h0,  32'h00008001};
        tbl[8]  = '{0,1,3'd6,32'h300,32'hFFFFFFFF,0,32'h0,      0, 0,0,0,4'h0,32'h0,       32'h0,  32'h00008001};
        tbl[9]  = '{1,0,3'd7,32'h300,32'h0,      0,32'h0,       0, 0,0,0,4'h0,32'h0,       32'h0,  32'h00008001};
        tbl[10] = '{1,1,3'd2,32'h208,32'hCAFEF00D,0,32'h0,      1, 3,1,1,4'hF,32'hCAFEF00D,32'h208,32'h00008001};
        tbl[11] = '{1,0,3'd2,32'h208,32'h0,      0,32'h0,       0, 2,1,0,4'hF,32'h0,       32'h208,32'hCAFEF00D};
        tbl[12] = '{1,0,3'd2,32'h200,32'h0,      0,32'h0,       0, 2,1,0,4'hF,32'h0,       32'h200,32'hABCD5500};

        for (int i = 0; i < 256; i++) dmem[i] = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_readdata", ReadData, 32'd0);
        check("rst_misaligned", {31'd0, Misaligned}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);

        // Reset while in REQ, then a stray ack two cycles later
        dmem[8'h40] = 32'h12345678;
        @(negedge clk); MemRead = 1'b1; funct3 = 3'd2; ALUResult = 32'h100;
        @(negedge clk); #1 check("rstreq_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; MemRead = 1'b0; #1;
        check("rstreq_req_dropped", {31'd0, mem_req}, 32'd0);
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk); mem_ack = 1'b0; #1;
        check("rstreq_req_after_ack", {31'd0, mem_req}, 32'd0);
        check("rstreq_readdata", ReadData, 32'd0);
        check("rstreq_stall", {31'd0, Stall}, 32'd0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].pre) dmem[tbl[i].addr[9:2]] = tbl[i].pre_val;
            run_access(tbl[i].mr, tbl[i].mw, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].waits, ns, nr);
            check($sformatf("v%0d_stall_cycles", i), 32'(ns), 32'(tbl[i].e_stall));
            check($sformatf("v%0d_requests", i), 32'(nr), 32'(tbl[i].e_req));
            check($sformatf("v%0d_readdata", i), ReadData, tbl[i].e_rd);
            if (tbl[i].e_req != 0) begin
                check($sformatf("v%0d_mem_addr", i), cap_addr, tbl[i].e_addr);
                check($sformatf("v%0d_mem_be", i), {28'd0, cap_be}, {28'd0, tbl[i].e_be});
                check($sformatf("v%0d_mem_we", i), {31'd0, cap_we}, {31'd0, tbl[i].e_we});
                if (tbl[i].e_we) check($sformatf("v%0d_mem_wdata", i), cap_wd, tbl[i].e_wd);
            end
        end

        // Randomized accesses against the byte-memory model
        for (int i = 0; i < 256; i++) begin
            dmem[i] = $urandom;
            for (int k = 0; k < 4; k++) refm[4*i + k] = dmem[i][8*k +: 8];
        end
        model_rd = 32'hABCD5500;
        for (int t = 0; t < 300; t++) begin
            int sel, waits;
            logic mr, mw;
            logic [2:0] f3;
            logic [31:0] addr, wd;
            sel = int'($urandom_range(0, 7));
            mr = (sel >= 1 && sel <= 4) || sel == 7;
            mw = (sel >= 5);
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 1023));
            wd = $urandom;
            waits = int'($urandom_range(0, 3));
            model_step(mr, mw, f3, addr, wd, acc, ebe, ewd, eaddr);
            run_access(mr, mw, f3, addr, wd, waits, ns, nr);
            check($sformatf("rnd%0d_stall_cycles", t), 32'(ns), acc ? 32'(waits + 2) : 32'd0);
            check($sformatf("rnd%0d_requests", t), 32'(nr), {31'd0, acc});
            check($sformatf("rnd%0d_readdata", t), ReadData, model_rd);
            if (acc) begin
                check($sformatf("rnd%0d_mem_addr", t), cap_addr, eaddr);
                check($sformatf("rnd%0d_mem_be", t), {28'd0, cap_be}, {28'd0, ebe});
                if (mw) check($sformatf("rnd%0d_mem_wdata", t), cap_wd, ewd);
            end
        end

        // Back-to-back SW then LW with zero-wait memory
        run_access(1'b0, 1'b1, 3'd2, 32'h10, 32'hA5A51234, 0, ns, nr);
        check("b2b_sw_stall", 32'(ns), 32'd2);
        run_access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 0, ns, nr2);
        check("b2b_lw_stall", 32'(ns), 32'd2);
        check("b2b_requests", 32'(nr + nr2), 32'd2);
        check("b2b_readdata", ReadData, 32'hA5A51234);
        idle_cycles(3, req_cnt);
        check("b2b_no_reissue", 32'(req_cnt), 32'd0);

        // Misaligned word load
        dmem[8'h40] = 32'h0BADF00D;
`ifdef MISALIGN_TRAP_EN
        @(negedge clk); MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'd2; ALUResult = 32'h101;
        #1 check("mis_stall", {31'd0, Stall}, 32'd0);
        mis_cnt = 0; req_cnt = (mem_req ? 1 : 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            MemRead = 1'b0;
            #1;
            if (Misaligned) mis_cnt++;
            if (mem_req) req_cnt++;
        end
        check("mis_pulse_cycles", 32'(mis_cnt), 32'd1);
        check("mis_requests", 32'(req_cnt), 32'd0);
        check("mis_readdata_kept", ReadData, 32'hA5A51234);
`else
        mis_cnt = 0;
        run_access(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 0, ns, nr);
        if (Misaligned) mis_cnt++;
        check("mis_mem_addr", cap_addr, 32'h100);
        check("mis_requests", 32'(nr), 32'd1);
        check("mis_readdata", ReadData, 32'h0BADF00D);
        idle_cycles(2, req_cnt);
        if (Misaligned) mis_cnt++;
        check("mis_flag_tied", 32'(mis_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data and address width.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 ALUResult  input  32  SHALL be the effective byte address.
REQ-005 WriteData  input  32  SHALL be the store data (rs2).
REQ-006 MemRead / MemWrite  input  1 each  SHALL be the load / store request.
REQ-007 funct3  input  3  SHALL encode access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 mem_req, mem_we  output  1 each  SHALL be the memory request and write strobe.
REQ-009 mem_addr  output  32  SHALL be the word-aligned address, with bits [1:0] = 0.
REQ-010 mem_wdata  output  32; mem_be  output  4  SHALL be the lane-aligned write data and byte enables.
REQ-011 mem_ack  input  1; mem_rdata  input  32  SHALL be the memory completion and read word.
REQ-012 ReadData  output  32  SHALL be the extended load result; Stall  output  1  SHALL be the pipeline hold; Misaligned  output  1  SHALL be the trap flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, REQ, DONE.
REQ-014 IDLE with a valid access SHALL register address, size and data, then go to REQ; with no valid access it SHALL stay in IDLE.
REQ-015 REQ SHALL hold mem_req = 1 and all mem_* outputs stable until mem_ack = 1, then go to DONE.
REQ-016 DONE SHALL go to IDLE unconditionally and SHALL NOT reissue the same access.
REQ-017 Stall SHALL be combinational: 1 in IDLE with a valid access, 1 in REQ, 0 in DONE.
REQ-018 Latency: ack in cycle k SHALL give ReadData valid and Stall = 0 in cycle k+1; zero-wait memory gives 3 cycles total.
REQ-019 When MemRead and MemWrite are both 1, the access SHALL be a store.
REQ-020 funct3 011/110/111 SHALL produce no access, Stall = 0, ReadData unchanged.
REQ-021 SB SHALL drive mem_be = 0001 << addr[1:0] and mem_wdata = the byte replicated 4x.
REQ-022 SH SHALL drive mem_be = 0011 << {addr[1],0} and mem_wdata = the half replicated 2x.
REQ-023 SW SHALL drive mem_be = 1111.
REQ-024 Loads SHALL drive mem_we = 0 and mem_be = 1111.
REQ-025 A load SHALL select its lane by addr[1:0], sign-extend for B/H, zero-extend for BU/HU, and register the result into ReadData on ack.
REQ-026 ReadData SHALL hold until the next load completes; stores SHALL NOT change it.
REQ-027 mem_ack received outside REQ SHALL be ignored.

Reset
REQ-028 rst SHALL force state IDLE, mem_req = 0, mem_we = 0, mem_be = 0, mem_addr = 0, mem_wdata = 0, ReadData = 0, Misaligned = 0.
REQ-029 rst asserted in REQ SHALL drop mem_req in the next cycle; a later ack SHALL be discarded.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: a misaligned access (H with addr[0] = 1, W with addr[1:0] != 0) SHALL issue no request, pulse Misaligned for 1 cycle, and hold Stall = 0.
REQ-031 Macro MISALIGN_TRAP_EN undefined: Misaligned SHALL be tied 0 and the offending low address bits SHALL be cleared to force natural alignment.

Structure
REQ-032 Package lsu_pkg SHALL hold the state enum, funct3 size constants and the BE patterns.
REQ-033 Sub-module lsu_load_align SHALL be combinational and perform lane select plus sign/zero extension.

Verification
REQ-034 LW at 0x100, mem_rdata = 0xDEADBEEF, ack after 2 waits: Stall = 1 for 4 cycles, then ReadData = 0xDEADBEEF.
REQ-035 LB at 0x103, mem_rdata = 0x80FF_0000: ReadData = 0xFFFF_FF80; LBU at the same address: ReadData = 0x0000_0080.
REQ-036 SH at 0x202, WriteData = 0x1234_ABCD: mem_be = 1100, mem_wdata = 0xABCD_ABCD, mem_addr = 0x200.
REQ-037 rst asserted in REQ, then ack 2 cycles later: state = IDLE, mem_req = 0, ReadData = 0.
REQ-038 LW at 0x101 with MISALIGN_TRAP_EN: Misaligned = 1 for 1 cycle, mem_req never 1. Without the macro: mem_addr = 0x100 and the load completes.
REQ-039 Back-to-back SW 0x10 then LW 0x10 with zero-wait memory: exactly two requests, LW returns the stored word.
